// File: rtl/n64adv_rst_sequencer.sv
// Ordered multi-channel reset release: hold, wait for stable PLL lock, then release channels in index order.
// Optional lock timeout enabled by defining N64ADV_RSTSEQ_LOCK_TIMEOUT_EN.
module n64adv_rst_sequencer #(
  parameter int unsigned N_CH        = 3,
  parameter int unsigned CFG_W       = 2,
  parameter int unsigned HOLD_CYC    = 16,
  parameter int unsigned LOCK_STABLE = 8,
  parameter int unsigned STAGE_GAP   = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
`ifdef N64ADV_RSTSEQ_LOCK_TIMEOUT_EN
  ,
  parameter int unsigned LOCK_TIMEOUT = 200
`endif
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             clk_en,
  input  logic             ext_nrst_i,
  input  logic             lock_i,
  input  logic [CFG_W-1:0] cfg_i,
  output logic [N_CH-1:0]  nrst_o,
  output logic             busy_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_WAIT_LOCK,
    ST_RELEASE,
    ST_RUN
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_RLD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_RLD = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] GAP_RLD  = CNT_W'(STAGE_GAP - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [N_CH-1:0]        nrst_d;
  logic                   busy_d;
  logic [SYNC_STAGES-1:0] ext_sync_q;
  logic [CFG_W-1:0]       cfg_q0, cfg_q1;
  logic                   trigger;
  logic                   release_now;

`ifdef N64ADV_RSTSEQ_LOCK_TIMEOUT_EN
  localparam int unsigned TCNT_W = 16;
  localparam logic [TCNT_W-1:0] TO_LAST = TCNT_W'(LOCK_TIMEOUT - 1);
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              timeout_d;
`endif

  // Any reset cause; PLL lock loss only matters once channels start releasing
  assign trigger = ~ext_sync_q[SYNC_STAGES-1]
                 | (cfg_q0 != cfg_q1)
                 | (~lock_i & ((state_q == ST_RELEASE) | (state_q == ST_RUN)));

  assign release_now = lock_i & (cnt_q == '0);

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nrst_d  = nrst_o;
`ifdef N64ADV_RSTSEQ_LOCK_TIMEOUT_EN
    tcnt_d    = tcnt_q;
    timeout_d = timeout_o;
`endif
    if (trigger) begin
      state_d = ST_ASSERT;
      cnt_d   = HOLD_RLD;
      nrst_d  = '0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (cnt_q == '0) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = LOCK_RLD;
`ifdef N64ADV_RSTSEQ_LOCK_TIMEOUT_EN
            tcnt_d  = '0;
`endif
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (!lock_i) begin
            cnt_d = LOCK_RLD;
          end else if (release_now) begin
            nrst_d  = N_CH'(1);
            cnt_d   = GAP_RLD;
            state_d = (N_CH == 1) ? ST_RUN : ST_RELEASE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
`ifdef N64ADV_RSTSEQ_LOCK_TIMEOUT_EN
          // Lock never settled: flag it and run the hold again
          if (!release_now) begin
            if (tcnt_q == TO_LAST) begin
              timeout_d = 1'b1;
              state_d   = ST_ASSERT;
              cnt_d     = HOLD_RLD;
            end else begin
              tcnt_d = tcnt_q + TCNT_W'(1);
            end
          end
`endif
        end
        ST_RELEASE: begin
          if (cnt_q == '0) begin
            nrst_d = (nrst_o << 1) | N_CH'(1);
            cnt_d  = GAP_RLD;
            if (nrst_d[N_CH-1]) state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q    <= ST_ASSERT;
      cnt_q      <= HOLD_RLD;
      nrst_o     <= '0;
      busy_o     <= 1'b1;
      ext_sync_q <= '1;
      cfg_q0     <= cfg_i;
      cfg_q1     <= cfg_i;
    end else if (clk_en) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nrst_o     <= nrst_d;
      busy_o     <= busy_d;
      ext_sync_q <= {ext_sync_q[SYNC_STAGES-2:0], ext_nrst_i};
      cfg_q0     <= cfg_i;
      cfg_q1     <= cfg_q0;
    end
  end

`ifdef N64ADV_RSTSEQ_LOCK_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst_i) begin
      tcnt_q    <= '0;
      timeout_o <= 1'b0;
    end else if (clk_en) begin
      tcnt_q    <= tcnt_d;
      timeout_o <= timeout_d;
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_n64adv_rst_sequencer.sv
// Directed bench for n64adv_rst_sequencer; edge numbers count posedges from the first reset edge (edge 0).
module tb_n64adv_rst_sequencer;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       clk_en = 1'b1;
  logic       ext_nrst_i = 1'b1;
  logic       lock_i = 1'b1;
  logic [1:0] cfg_i = 2'd0;
  logic [2:0] nrst_o;
  logic       busy_o;
  logic       timeout_o;

  int checks = 0;
  int failures = 0;
  int edge_no = -1;

  always #5 clk = ~clk;

`ifdef N64ADV_RSTSEQ_LOCK_TIMEOUT_EN
  n64adv_rst_sequencer #(.LOCK_TIMEOUT(50)) dut (
`else
  n64adv_rst_sequencer dut (
`endif
    .clk       (clk),
    .rst_i     (rst_i),
    .clk_en    (clk_en),
    .ext_nrst_i(ext_nrst_i),
    .lock_i    (lock_i),
    .cfg_i     (cfg_i),
    .nrst_o    (nrst_o),
    .busy_o    (busy_o),
    .timeout_o (timeout_o)
  );

  // Advance to just after the given edge
  task automatic go_to(input int e);
    while (edge_no < e) begin
      @(posedge clk);
      #1;
      edge_no++;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_no, obs, exp);
    end
  endtask

  initial begin
    // Reset and power-up release
    go_to(0);
    chk("rst_nrst", 8'(nrst_o), 8'h00);
    chk("rst_busy", 8'(busy_o), 8'h01);
    chk("rst_tmo", 8'(timeout_o), 8'h00);
    rst_i = 1'b0;
    go_to(23); chk("pu_e23", 8'(nrst_o), 8'h00);
    go_to(24); chk("pu_e24", 8'(nrst_o), 8'h01); chk("pu_busy24", 8'(busy_o), 8'h01);
    go_to(27); chk("pu_e27", 8'(nrst_o), 8'h01);
    go_to(28); chk("pu_e28", 8'(nrst_o), 8'h03);
    go_to(31); chk("pu_e31", 8'(nrst_o), 8'h03); chk("pu_busy31", 8'(busy_o), 8'h01);
    go_to(32); chk("pu_e32", 8'(nrst_o), 8'h07); chk("pu_busy32", 8'(busy_o), 8'h00);

    // Config change sampled at edge 33, second change sampled at 42 extends hold
    cfg_i = 2'd2;
    go_to(33); chk("cfg_e33", 8'(nrst_o), 8'h07);
    go_to(34); chk("cfg_e34", 8'(nrst_o), 8'h00); chk("cfg_busy34", 8'(busy_o), 8'h01);
    go_to(41); cfg_i = 2'd1;
    go_to(58); chk("cfg_ext_e58", 8'(nrst_o), 8'h00);
    go_to(66); chk("cfg_e66", 8'(nrst_o), 8'h00);
    go_to(67); chk("cfg_e67", 8'(nrst_o), 8'h01);
    go_to(71); chk("cfg_e71", 8'(nrst_o), 8'h03);
    go_to(75); chk("cfg_e75", 8'(nrst_o), 8'h07); chk("cfg_busy75", 8'(busy_o), 8'h00);

    // One-cycle lock loss in RUN, then a lock glitch during WAIT_LOCK (entered at 92)
    lock_i = 1'b0;
    go_to(76); chk("lock_e76", 8'(nrst_o), 8'h00);
    lock_i = 1'b1;
    go_to(96); lock_i = 1'b0;
    go_to(97); lock_i = 1'b1;
    go_to(100); chk("lockw_e100", 8'(nrst_o), 8'h00);
    go_to(104); chk("lockw_e104", 8'(nrst_o), 8'h00);
    go_to(105); chk("lockw_e105", 8'(nrst_o), 8'h01);
    go_to(113); chk("lockw_e113", 8'(nrst_o), 8'h07);

    // External request pulse goes through the 2-flop synchroniser
    ext_nrst_i = 1'b0;
    go_to(114); ext_nrst_i = 1'b1;
    go_to(115); chk("ext_e115", 8'(nrst_o), 8'h07);
    go_to(116); chk("ext_e116", 8'(nrst_o), 8'h00);

    // Clock-enable freeze: 10 edges in ASSERT, then 10 edges in RELEASE with lock noise
    go_to(120); clk_en = 1'b0;
    go_to(125); chk("frz_a_nrst", 8'(nrst_o), 8'h00); chk("frz_a_busy", 8'(busy_o), 8'h01);
    go_to(130); clk_en = 1'b1;
    go_to(140); chk("frz_e140", 8'(nrst_o), 8'h00);
    go_to(149); chk("frz_e149", 8'(nrst_o), 8'h00);
    go_to(150); chk("frz_e150", 8'(nrst_o), 8'h01);
    go_to(151); clk_en = 1'b0;
    go_to(154); chk("frz_e154", 8'(nrst_o), 8'h01);
    lock_i = 1'b0;
    go_to(156); lock_i = 1'b1;
    go_to(161); clk_en = 1'b1;
    go_to(163); chk("frz_e163", 8'(nrst_o), 8'h01);
    go_to(164); chk("frz_e164", 8'(nrst_o), 8'h03);
    go_to(167); chk("frz_busy167", 8'(busy_o), 8'h01);
    go_to(168); chk("frz_e168", 8'(nrst_o), 8'h07); chk("frz_busy168", 8'(busy_o), 8'h00);

    // rst_i mid-RELEASE with clk_en low
    cfg_i = 2'd3;
    go_to(170); chk("r5_e170", 8'(nrst_o), 8'h00);
    go_to(194); chk("r5_e194", 8'(nrst_o), 8'h01);
    go_to(195); chk("r5_e195", 8'(nrst_o), 8'h01);
    rst_i = 1'b1; clk_en = 1'b0;
    go_to(196);
    chk("r5_nrst", 8'(nrst_o), 8'h00);
    chk("r5_busy", 8'(busy_o), 8'h01);
    chk("r5_tmo", 8'(timeout_o), 8'h00);
    rst_i = 1'b0; clk_en = 1'b1;
    go_to(219); chk("r5_e219", 8'(nrst_o), 8'h00);
    go_to(220); chk("r5_e220", 8'(nrst_o), 8'h01);
    go_to(224); chk("r5_e224", 8'(nrst_o), 8'h03);
    go_to(228); chk("r5_e228", 8'(nrst_o), 8'h07); chk("r5_busy228", 8'(busy_o), 8'h00);

    // Lock held low: trigger at 229, WAIT_LOCK entered at 245
    lock_i = 1'b0;
    go_to(229); chk("to_e229", 8'(nrst_o), 8'h00); chk("to_busy229", 8'(busy_o), 8'h01);
`ifdef N64ADV_RSTSEQ_LOCK_TIMEOUT_EN
    go_to(294); chk("to_e294", 8'(timeout_o), 8'h00);
    go_to(295); chk("to_e295", 8'(timeout_o), 8'h01); chk("to_nrst295", 8'(nrst_o), 8'h00);
    lock_i = 1'b1;
    go_to(318); chk("to_e318", 8'(nrst_o), 8'h00);
    go_to(319); chk("to_e319", 8'(nrst_o), 8'h01); chk("to_sticky", 8'(timeout_o), 8'h01);
`else
    go_to(545);
    chk("nto_nrst", 8'(nrst_o), 8'h00);
    chk("nto_busy", 8'(busy_o), 8'h01);
    chk("nto_tmo", 8'(timeout_o), 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
